// File: rtl/player_motion_controller.sv
// Per-frame player position updater: requests a collision check around the current tile,
// then applies horizontal input, jump and gravity against the returned solid-neighbour flags.
module player_motion_controller #(
  parameter int unsigned X_MAX       = 1999,
  parameter int unsigned X_START     = 2,
  parameter int unsigned Y_START     = 10,
  parameter int unsigned JUMP_HEIGHT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic        blocked_left,
  input  logic        blocked_right,
  input  logic        blocked_up,
  input  logic        blocked_down,
  input  logic        collide_done,
  output logic        collide_enable,
  output logic [10:0] x_location,
  output logic [3:0]  y_location,
  output logic        airborne,
  output logic        update_done
);

  localparam logic [10:0] X_MAX_L   = X_MAX[10:0];
  localparam logic [10:0] X_START_L = X_START[10:0];
  localparam logic [3:0]  Y_START_L = Y_START[3:0];
  localparam logic [3:0]  JUMP_L    = JUMP_HEIGHT[3:0];

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_MOVE_X, S_MOVE_Y, S_RELEASE, S_DONE
  } state_e;

  typedef struct packed {
    logic left;
    logic right;
    logic up;
    logic down;
  } flags_t;

  state_e      state_q, state_d;
  flags_t      flags_q, flags_d;
  logic [10:0] x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic [3:0]  jc_q, jc_d;
  logic [3:0]  jc_eff;
  logic        air_q, air_d;
  logic        enable_q, enable_d;
  logic        done_q, done_d;

  // State register and all datapath flops share one synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      flags_q  <= '0;
      x_q      <= X_START_L;
      y_q      <= Y_START_L;
      jc_q     <= '0;
      air_q    <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      x_q      <= x_d;
      y_q      <= y_d;
      jc_q     <= jc_d;
      air_q    <= air_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (frame_tick)    state_d = S_REQ;
      S_REQ:     if (collide_done)  state_d = S_MOVE_X;
      S_MOVE_X:                     state_d = S_MOVE_Y;
      S_MOVE_Y:                     state_d = S_RELEASE;
      S_RELEASE: if (!collide_done) state_d = S_DONE;
      S_DONE:                       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the matching cycle.
  always_comb begin
    enable_d = (state_d == S_REQ) || (state_d == S_MOVE_X) || (state_d == S_MOVE_Y);
    done_d   = (state_d == S_DONE);
  end

  always_comb begin
    flags_d = flags_q;
    x_d     = x_q;
    y_d     = y_q;
    jc_d    = jc_q;
    air_d   = air_q;
    jc_eff  = jc_q;

    if (state_q == S_REQ && collide_done) begin
      flags_d = '{left: blocked_left, right: blocked_right, up: blocked_up, down: blocked_down};
    end

    if (state_q == S_MOVE_X) begin
      if (btn_right && !btn_left && !flags_q.right && x_q < X_MAX_L) begin
        x_d = x_q + 11'd1;
      end else if (btn_left && !btn_right && !flags_q.left && x_q != 11'd0) begin
        x_d = x_q - 11'd1;
      end
    end

    if (state_q == S_MOVE_Y) begin
      // A jump that starts this frame also rises this frame.
      if (jc_q == 4'd0 && flags_q.down && btn_jump) begin
        jc_eff = JUMP_L;
      end
      if (jc_eff != 4'd0) begin
        if (!flags_q.up && y_q != 4'd0) begin
          y_d  = y_q - 4'd1;
          jc_d = jc_eff - 4'd1;
        end else begin
          jc_d = 4'd0;
        end
      end else if (!flags_q.down && y_q != 4'd15) begin
        y_d = y_q + 4'd1;
      end
      air_d = (jc_d != 4'd0) || (!flags_q.down && y_d != 4'd15);
    end
  end

  assign collide_enable = enable_q;
  assign x_location     = x_q;
  assign y_location     = y_q;
  assign airborne       = air_q;
  assign update_done    = done_q;

endmodule
